load_store_unit: RTL and testbench

Sits between the execute stage and the `memory` block; turns ARM LDR/STR/LDRB/STRB/LDRH/STRH requests into word-wide accesses on the single memory port. It handles byte-lane alignment, sign and zero extension, and read-modify-write for sub-word stores. Misaligned accesses, reserved sizes and stores into the ROM region are rejected with a fault instead of reaching memory.

---
 rtl/lsu_pkg.sv | 47 ++++
 rtl/lsu_if.sv | 28 ++
 rtl/lsu_lane_align.sv | 52 +++++
 rtl/load_store_unit.sv | 154 +++++++++++++++
 tb/tb_load_store_unit.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM states,
// the latched request record and the access-fault rule.
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int unsigned ROM_END_DEFAULT = 32'd64000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAPT = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } lsu_state_e;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        is_signed;
        logic [1:0]  lane;
        logic [31:0] wdata;
    } lsu_req_t;

    // Misalignment, reserved size, or a store below the ROM boundary.
    function automatic logic access_fault(input logic        write,
                                          input logic [1:0]  size,
                                          input logic [31:0] addr,
                                          input logic [31:0] rom_end);
        logic f;
        case (size)
            SIZE_BYTE: f = 1'b0;
            SIZE_HALF: f = addr[0];
            SIZE_WORD: f = (addr[1:0] != 2'b00);
            default:   f = 1'b1;
        endcase
        if (write && (addr < rom_end)) begin
            f = 1'b1;
        end else begin
            f = f;
        end
        return f;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response bus from the execute stage and the single-port memory bus.
interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    modport master (output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
                    input  req_ready, resp_valid, resp_rdata, resp_fault);
    modport slave  (input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
                    output req_ready, resp_valid, resp_rdata, resp_fault);
endinterface

interface lsu_mem_if;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_write;
    logic [31:0] mem_data_out;

    modport master (output mem_address, mem_data_in, mem_write, input mem_data_out);
    modport slave  (input mem_address, mem_data_in, mem_write, output mem_data_out);
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: extract/extend a loaded lane and merge a
// sub-word store lane into the word read back from memory.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [4:0]  shamt_s;
    logic [31:0] shifted_s;
    logic [31:0] mask_s;
    logic [31:0] ins_s;

    // Little-endian lane select, extension and store-lane merge
    always_comb begin
        shamt_s   = {lane, 3'b000};
        shifted_s = rd_word >> shamt_s;
        load_data = 32'h0000_0000;
        mask_s    = 32'h0000_0000;
        ins_s     = 32'h0000_0000;
        case (size)
            SIZE_BYTE: begin
                load_data = {{24{is_signed & shifted_s[7]}}, shifted_s[7:0]};
                mask_s    = 32'h0000_00FF << shamt_s;
                ins_s     = {24'h00_0000, wdata[7:0]} << shamt_s;
            end
            SIZE_HALF: begin
                load_data = {{16{is_signed & shifted_s[15]}}, shifted_s[15:0]};
                mask_s    = 32'h0000_FFFF << shamt_s;
                ins_s     = {16'h0000, wdata[15:0]} << shamt_s;
            end
            SIZE_WORD: begin
                load_data = rd_word;
                mask_s    = 32'hFFFF_FFFF;
                ins_s     = wdata;
            end
            default: begin
                load_data = 32'h0000_0000;
                mask_s    = 32'h0000_0000;
                ins_s     = 32'h0000_0000;
            end
        endcase
        merge_data = (rd_word & ~mask_s) | ins_s;
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: converts byte/half/word requests into word accesses on a
// single memory port, with read-modify-write for sub-word stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ROM_END = ROM_END_DEFAULT
) (
    input logic        clk,
    input logic        reset,
    lsu_req_if.slave   req,
    lsu_mem_if.master  mem
);

    lsu_state_e  state_r, next_state_s;
    lsu_req_t    req_r;
    logic        accept_s, fault_s;
    logic [31:0] load_data_s, merge_data_s;

    logic        resp_valid_r, resp_valid_s;
    logic        resp_fault_r, resp_fault_s;
    logic [31:0] resp_rdata_r, resp_rdata_s;
    logic [31:0] mem_address_r, mem_address_s;
    logic [31:0] mem_data_in_r, mem_data_in_s;
    logic        mem_write_r, mem_write_s;

    assign accept_s = (state_r == ST_IDLE) && req.req_valid;
    assign fault_s  = access_fault(req.req_write, req.req_size, req.req_addr, ROM_END);

    lsu_lane_align u_align (
        .rd_word    (mem.mem_data_out),
        .lane       (req_r.lane),
        .size       (req_r.size),
        .is_signed  (req_r.is_signed),
        .wdata      (req_r.wdata),
        .load_data  (load_data_s),
        .merge_data (merge_data_s)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request capture on acceptance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_r <= '0;
        end else if (accept_s) begin
            req_r <= '{write:     req.req_write,
                       size:      req.req_size,
                       is_signed: req.req_signed,
                       lane:      req.req_addr[1:0],
                       wdata:     req.req_wdata};
        end
    end

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s) begin
                    next_state_s = ST_IDLE;
                end else if (fault_s) begin
                    next_state_s = ST_RESP;
                end else if (req.req_write && (req.req_size == SIZE_WORD)) begin
                    next_state_s = ST_WR;
                end else begin
                    next_state_s = ST_RD;
                end
            end
            ST_RD:   next_state_s = ST_CAPT;
            ST_CAPT: begin
                if (req_r.write) begin
                    next_state_s = ST_WR;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            ST_WR:   next_state_s = ST_RESP;
            ST_RESP: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output decode: values the output registers take at the next edge
    always_comb begin
        resp_valid_s  = (next_state_s == ST_RESP);
        mem_write_s   = (next_state_s == ST_WR);
        resp_fault_s  = resp_fault_r;
        resp_rdata_s  = resp_rdata_r;
        mem_address_s = mem_address_r;
        mem_data_in_s = mem_data_in_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    resp_fault_s = fault_s;
                    resp_rdata_s = 32'h0000_0000;
                    if (!fault_s) begin
                        mem_address_s = {req.req_addr[31:2], 2'b00};
                        mem_data_in_s = req.req_wdata;
                    end else begin
                        mem_address_s = mem_address_r;
                    end
                end else begin
                    resp_fault_s = resp_fault_r;
                end
            end
            // The read word only exists at the closing CAPT edge, so extract/merge here
            ST_CAPT: begin
                if (req_r.write) begin
                    mem_data_in_s = merge_data_s;
                end else begin
                    resp_rdata_s = load_data_s;
                end
            end
            default: begin
                resp_fault_s = resp_fault_r;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid_r  <= 1'b0;
            resp_fault_r  <= 1'b0;
            resp_rdata_r  <= 32'h0000_0000;
            mem_address_r <= 32'h0000_0000;
            mem_data_in_r <= 32'h0000_0000;
            mem_write_r   <= 1'b0;
        end else begin
            resp_valid_r  <= resp_valid_s;
            resp_fault_r  <= resp_fault_s;
            resp_rdata_r  <= resp_rdata_s;
            mem_address_r <= mem_address_s;
            mem_data_in_r <= mem_data_in_s;
            mem_write_r   <= mem_write_s;
        end
    end

    assign req.req_ready    = (state_r == ST_IDLE);
    assign req.resp_valid   = resp_valid_r;
    assign req.resp_fault   = resp_fault_r;
    assign req.resp_rdata   = resp_rdata_r;
    assign mem.mem_address  = mem_address_r;
    assign mem.mem_data_in  = mem_data_in_r;
    assign mem.mem_write    = mem_write_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of single requests plus
// hand-written reset-abort and back-to-back sequences.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    lsu_req_if req_bus ();
    lsu_mem_if mem_bus ();

    load_store_unit dut (
        .clk   (clk),
        .reset (reset),
        .req   (req_bus),
        .mem   (mem_bus)
    );

    // Synchronous single-port memory with a bench-side preload port
    logic [31:0] mem_q [0:255];
    logic        pl_en = 1'b0;
    logic [31:0] pl_addr = 32'h0;
    logic [31:0] pl_data = 32'h0;

    always @(posedge clk) begin
        mem_bus.mem_data_out <= mem_q[mem_bus.mem_address[9:2]];
        if (pl_en) mem_q[pl_addr[9:2]] <= pl_data;
        if (mem_bus.mem_write) mem_q[mem_bus.mem_address[9:2]] <= mem_bus.mem_data_in;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_cyc;
        int          exp_wr;
        logic [31:0] exp_mem;
    } vec_t;

    // Issue one request; report latency in edges after the accepting edge
    task automatic do_req(input vec_t v, output logic [31:0] rd, output logic flt,
                          output int cyc, output int nwr);
        int guard;
        @(negedge clk);
        req_bus.req_write = v.wr; req_bus.req_size = v.size; req_bus.req_signed = v.sgn;
        req_bus.req_addr = v.addr; req_bus.req_wdata = v.wdata; req_bus.req_valid = 1'b1;
        guard = 0;
        while (!req_bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 req_bus.req_valid = 1'b0;
        cyc = -1; nwr = 0; rd = 32'h0; flt = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (mem_bus.mem_write) nwr++;
            if (req_bus.resp_valid && cyc < 0) begin
                cyc = k;
                rd  = req_bus.resp_rdata;
                flt = req_bus.resp_fault;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[15];
        logic [31:0] rd;
        logic flt;
        int cyc, nwr, ev_wr, ev_rv;
        int acc[$];
        logic [31:0] rds[$];

        vecs[0]  = '{"ldr_100",    1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,         32'h1122_3344, 32'h1122_3344, 1'b0, 3, 0, 32'h1122_3344};
        vecs[1]  = '{"ldrb_s_3",   1'b0, 2'b00, 1'b1, 32'h0001_0003, 32'h0,         32'h80FF_7F01, 32'hFFFF_FF80, 1'b0, 3, 0, 32'h80FF_7F01};
        vecs[2]  = '{"ldrb_u_3",   1'b0, 2'b00, 1'b0, 32'h0001_0003, 32'h0,         32'h80FF_7F01, 32'h0000_0080, 1'b0, 3, 0, 32'h80FF_7F01};
        vecs[3]  = '{"ldrh_s_0",   1'b0, 2'b01, 1'b1, 32'h0001_0000, 32'h0,         32'h80FF_7F01, 32'h0000_7F01, 1'b0, 3, 0, 32'h80FF_7F01};
        vecs[4]  = '{"ldrh_s_2",   1'b0, 2'b01, 1'b1, 32'h0001_0002, 32'h0,         32'h80FF_7F01, 32'hFFFF_80FF, 1'b0, 3, 0, 32'h80FF_7F01};
        vecs[5]  = '{"ldrb_s_1",   1'b0, 2'b00, 1'b1, 32'h0001_0001, 32'h0,         32'h80FF_7F01, 32'h0000_007F, 1'b0, 3, 0, 32'h80FF_7F01};
        vecs[6]  = '{"ldrh_u_2",   1'b0, 2'b01, 1'b0, 32'h0001_0002, 32'h0,         32'h80FF_7F01, 32'h0000_80FF, 1'b0, 3, 0, 32'h80FF_7F01};
        vecs[7]  = '{"strh_2",     1'b1, 2'b01, 1'b0, 32'h0001_0002, 32'h0000_BEEF, 32'h1122_3344, 32'h0,         1'b0, 4, 1, 32'hBEEF_3344};
        vecs[8]  = '{"strb_1",     1'b1, 2'b00, 1'b0, 32'h0001_0001, 32'hFFFF_FFAA, 32'h1122_3344, 32'h0,         1'b0, 4, 1, 32'h1122_AA44};
        vecs[9]  = '{"str_word",   1'b1, 2'b10, 1'b0, 32'h0001_0004, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0,         1'b0, 2, 1, 32'hDEAD_BEEF};
        vecs[10] = '{"str_rom",    1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'hCAFE_F00D, 32'h5555_5555, 32'h0,         1'b1, 1, 0, 32'h5555_5555};
        vecs[11] = '{"ldr_mis",    1'b0, 2'b10, 1'b0, 32'h0001_0001, 32'h0,         32'h1234_5678, 32'h0,         1'b1, 1, 0, 32'h1234_5678};
        vecs[12] = '{"size_rsvd",  1'b0, 2'b11, 1'b0, 32'h0001_0000, 32'h0,         32'h1234_5678, 32'h0,         1'b1, 1, 0, 32'h1234_5678};
        vecs[13] = '{"strb_rom_e", 1'b1, 2'b00, 1'b0, 32'h0000_F9FF, 32'h0000_0077, 32'h1122_3344, 32'h0,         1'b1, 1, 0, 32'h1122_3344};
        vecs[14] = '{"strb_ram_b", 1'b1, 2'b00, 1'b0, 32'h0000_FA00, 32'h0000_0077, 32'h1122_3344, 32'h0,         1'b0, 4, 1, 32'h1122_3377};

        req_bus.req_valid = 1'b0; req_bus.req_write = 1'b0; req_bus.req_size = 2'b00;
        req_bus.req_signed = 1'b0; req_bus.req_addr = 32'h0; req_bus.req_wdata = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready",   32'(req_bus.req_ready),  32'h1);
        check("rst_resp_valid",  32'(req_bus.resp_valid), 32'h0);
        check("rst_resp_fault",  32'(req_bus.resp_fault), 32'h0);
        check("rst_mem_write",   32'(mem_bus.mem_write),  32'h0);
        check("rst_resp_rdata",  req_bus.resp_rdata,      32'h0);
        check("rst_mem_address", mem_bus.mem_address,     32'h0);
        check("rst_mem_data_in", mem_bus.mem_data_in,     32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Vector table
        for (int i = 0; i < 15; i++) begin
            preload({vecs[i].addr[31:2], 2'b00}, vecs[i].init);
            do_req(vecs[i], rd, flt, cyc, nwr);
            check({vecs[i].name, "_rdata"},  rd,          vecs[i].exp_rdata);
            check({vecs[i].name, "_fault"},  32'(flt),    32'(vecs[i].exp_fault));
            check({vecs[i].name, "_cycle"},  32'(cyc),    32'(vecs[i].exp_cyc));
            check({vecs[i].name, "_writes"}, 32'(nwr),    32'(vecs[i].exp_wr));
            check({vecs[i].name, "_mem"},    mem_q[vecs[i].addr[9:2]], vecs[i].exp_mem);
        end

        // Reset during CAPT of a sub-word store aborts it
        preload(32'h0001_0000, 32'h1122_3344);
        @(negedge clk);
        req_bus.req_write = 1'b1; req_bus.req_size = 2'b00; req_bus.req_signed = 1'b0;
        req_bus.req_addr = 32'h0001_0001; req_bus.req_wdata = 32'h0000_00AA; req_bus.req_valid = 1'b1;
        @(posedge clk);
        #1 req_bus.req_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_capt_mem_write", 32'(mem_bus.mem_write), 32'h0);
        check("abort_capt_ready",     32'(req_bus.req_ready), 32'h1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ev_wr = 0; ev_rv = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_bus.mem_write) ev_wr++;
            if (req_bus.resp_valid) ev_rv++;
        end
        check("abort_capt_no_write", 32'(ev_wr), 32'h0);
        check("abort_capt_no_resp",  32'(ev_rv), 32'h0);
        check("abort_capt_mem",      mem_q[8'h00], 32'h1122_3344);
        check("abort_capt_ready2",   32'(req_bus.req_ready), 32'h1);

        // Reset while the write strobe is high drops it immediately
        preload(32'h0001_0004, 32'h0BAD_F00D);
        @(negedge clk);
        req_bus.req_write = 1'b1; req_bus.req_size = 2'b10;
        req_bus.req_addr = 32'h0001_0004; req_bus.req_wdata = 32'h1357_9BDF; req_bus.req_valid = 1'b1;
        @(posedge clk);
        #1 req_bus.req_valid = 1'b0;
        #1;
        check("abort_wr_strobe_high", 32'(mem_bus.mem_write), 32'h1);
        reset = 1'b0;
        #1;
        check("abort_wr_strobe_drop", 32'(mem_bus.mem_write), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_wr_mem", mem_q[8'h01], 32'h0BAD_F00D);

        // Back-to-back loads with req_valid held high
        preload(32'h0000_0100, 32'h1122_3344);
        @(negedge clk);
        req_bus.req_write = 1'b0; req_bus.req_size = 2'b10; req_bus.req_signed = 1'b0;
        req_bus.req_addr = 32'h0000_0100; req_bus.req_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            if (req_bus.resp_valid) rds.push_back(req_bus.resp_rdata);
            if (req_bus.req_ready) acc.push_back(k);
            if (k != 0 && k != 4) check($sformatf("b2b_ready_busy_%0d", k), 32'(req_bus.req_ready), 32'h0);
        end
        req_bus.req_valid = 1'b0;
        check("b2b_accepts", 32'(acc.size()), 32'h2);
        if (acc.size() == 2) check("b2b_gap", 32'(acc[1] - acc[0]), 32'h4);
        check("b2b_resps", 32'(rds.size()), 32'h2);
        if (rds.size() == 2) begin
            check("b2b_rdata0", rds[0], 32'h1122_3344);
            check("b2b_rdata1", rds[1], 32'h1122_3344);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
